// File: rtl/request_pkg.sv
// Shared constants and types for the two-channel request stager.
// Channel FSM encoding and default sizing live here so both levels agree.
package request_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int TAG_W_DEF = 4;
    localparam int HOLD_DEF  = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } chan_state_t;

    typedef logic [TAG_W_DEF-1:0] tag_t;

endpackage

// File: rtl/req_channel.sv
// One requester channel: circular tag FIFO, request FSM and post-grant hold-off.
// A request is raised only in REQ, so each arbiter grant pops exactly one entry.
module req_channel
    import request_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int HOLD  = HOLD_DEF,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [TAG_W-1:0] tag,
    input  logic             G,
    output logic             R,
    output logic             gnt_valid,
    output logic [TAG_W-1:0] gnt_tag,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD + 1);

    logic [TAG_W-1:0] mem [DEPTH];

    chan_state_t      state_reg, state_next;
    logic [PW-1:0]    head_reg, head_next;
    logic [PW-1:0]    tail_reg, tail_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [HW-1:0]    hold_reg, hold_next;
    logic             gnt_valid_reg;
    logic [TAG_W-1:0] gnt_tag_reg;

    logic full_now;
    logic pop;
    logic push_acc;

    // Grant only counts in REQ; in any other state G may be X and is masked.
    assign full_now = (count_reg == CW'(DEPTH));
    assign pop      = (state_reg == REQ) && G;
    assign push_acc = push && (!full_now || pop);
    assign drop     = push && full_now && !pop;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg + CW'(push_acc) - CW'(pop);
        state_next = state_reg;
        hold_next  = hold_reg;

        if (pop)      head_next = head_reg + PW'(1);
        if (push_acc) tail_next = tail_reg + PW'(1);

        case (state_reg)
            IDLE: begin
                if (push_acc) state_next = REQ;
            end
            REQ: begin
                if (pop) begin
                    state_next = HOLDOFF;
                    hold_next  = HW'(HOLD);
                end
            end
            HOLDOFF: begin
                // Expiry looks at occupancy after this edge so a push landing
                // on the last hold cycle still re-arms the request.
                if (hold_reg <= HW'(1)) begin
                    state_next = (count_next != '0) ? REQ : IDLE;
                end else begin
                    hold_next = hold_reg - HW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            hold_reg      <= '0;
            gnt_valid_reg <= 1'b0;
            gnt_tag_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            count_reg     <= count_next;
            hold_reg      <= hold_next;
            gnt_valid_reg <= pop;
            if (pop) gnt_tag_reg <= mem[head_reg];
        end
    end

    // Storage carries no reset; pointers and count define what is live.
    always_ff @(posedge clock) begin
        if (reset && push_acc) mem[tail_reg] <= tag;
    end

    assign R         = (state_reg == REQ);
    assign gnt_valid = gnt_valid_reg;
    assign gnt_tag   = gnt_tag_reg;
    assign full      = full_now;
    assign count     = count_reg;

endmodule

// File: rtl/request_stager.sv
// Two-channel request stager feeding the grant arbiter.
// Each channel is an independent req_channel; dropped pushes set a sticky overflow.
module request_stager
    import request_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int HOLD  = HOLD_DEF,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push0,
    input  logic [TAG_W-1:0] tag0,
    input  logic             push1,
    input  logic [TAG_W-1:0] tag1,
    input  logic             G0,
    input  logic             G1,
    output logic             R0,
    output logic             R1,
    output logic             gnt0_valid,
    output logic [TAG_W-1:0] gnt0_tag,
    output logic             gnt1_valid,
    output logic [TAG_W-1:0] gnt1_tag,
    output logic             full0,
    output logic             full1,
    output logic [CW-1:0]    count0,
    output logic [CW-1:0]    count1,
    output logic             overflow
);

    logic [1:0]       push_vec;
    logic [1:0]       g_vec;
    logic [1:0]       r_vec;
    logic [1:0]       gv_vec;
    logic [1:0]       full_vec;
    logic [1:0]       drop_vec;
    logic [TAG_W-1:0] tag_in   [2];
    logic [TAG_W-1:0] tag_out  [2];
    logic [CW-1:0]    count_out[2];
    logic             overflow_reg;

    assign push_vec  = {push1, push0};
    assign g_vec     = {G1, G0};
    assign tag_in[0] = tag0;
    assign tag_in[1] = tag1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            req_channel #(
                .DEPTH (DEPTH),
                .TAG_W (TAG_W),
                .HOLD  (HOLD)
            ) u_chan (
                .clock     (clock),
                .reset     (reset),
                .push      (push_vec[gi]),
                .tag       (tag_in[gi]),
                .G         (g_vec[gi]),
                .R         (r_vec[gi]),
                .gnt_valid (gv_vec[gi]),
                .gnt_tag   (tag_out[gi]),
                .full      (full_vec[gi]),
                .count     (count_out[gi]),
                .drop      (drop_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) overflow_reg <= 1'b0;
        else        overflow_reg <= overflow_reg | (|drop_vec);
    end

    assign R0         = r_vec[0];
    assign R1         = r_vec[1];
    assign gnt0_valid = gv_vec[0];
    assign gnt1_valid = gv_vec[1];
    assign gnt0_tag   = tag_out[0];
    assign gnt1_tag   = tag_out[1];
    assign full0      = full_vec[0];
    assign full1      = full_vec[1];
    assign count0     = count_out[0];
    assign count1     = count_out[1];
    assign overflow   = overflow_reg;

endmodule

// File: doc/request_stager.md
# request_stager

Upstream feeder for the two-requester grant arbiter. Two independent requester channels push tagged requests into small per-channel FIFOs. The stager drives the arbiter's `R0`/`R1` request lines from FIFO occupancy and consumes the arbiter's `G0`/`G1` grants. On each accepted grant it pops the head tag and reports it to the winning requester, so the arbiter only ever sees one clean request per outstanding entry.

## Interface
Parameters:
- `DEPTH`, 4: entries per channel FIFO; power of two, ≥2.
- `TAG_W`, 4: request tag width.
- `HOLD`, 1: cycles `Ri` stays low after a pop on channel i; ≥1.

Ports (`CW` = $clog2(DEPTH+1)):
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low.
- `push0` in 1: enqueue `tag0` on channel 0 this cycle.
- `tag0` in TAG_W: channel 0 request tag.
- `push1` in 1: enqueue `tag1` on channel 1 this cycle.
- `tag1` in TAG_W: channel 1 request tag.
- `G0` in 1: arbiter grant line 0.
- `G1` in 1: arbiter grant line 1.
- `R0` out 1: registered request to arbiter, channel 0.
- `R1` out 1: registered request to arbiter, channel 1.
- `gnt0_valid` out 1: one-cycle pulse; channel 0 head was granted.
- `gnt0_tag` out TAG_W: tag popped for channel 0; valid only with `gnt0_valid`.
- `gnt1_valid` out 1: one-cycle pulse; channel 1 head was granted.
- `gnt1_tag` out TAG_W: tag popped for channel 1; valid only with `gnt1_valid`.
- `full0` out 1: channel 0 FIFO full.
- `full1` out 1: channel 1 FIFO full.
- `count0` out CW: channel 0 occupancy.
- `count1` out CW: channel 1 occupancy.
- `overflow` out 1: sticky; a push was dropped.

## Operation
- **Channel FIFO.** Each channel is a circular FIFO with head/tail pointers of width log2(DEPTH), wrapping modulo DEPTH. Occupancy is a CW-bit counter.
- **Per-channel FSM.**
  - IDLE: count==0, `Ri`=0.
  - REQ: count>0, `Ri`=1.
  - HOLDOFF: `Ri`=0, hold counter running.
- **Transitions.**
  - IDLE→REQ when a push makes count>0.
  - REQ→HOLDOFF on a valid grant.
  - HOLDOFF→REQ when the hold counter expires and count>0.
  - HOLDOFF→IDLE when the hold counter expires and count==0.
- **Valid grant.** `Gi`==1 sampled while the channel is in REQ. `Gi` is ignored (may be X) in IDLE or HOLDOFF; ignored grants pop nothing.
- **Valid grant action.** Pop the head, load `gnti_tag`=head tag, pulse `gnti_valid`, load the hold counter with HOLD.
- **Simultaneous G0 and G1.** Each channel is processed independently; both may pop in the same cycle.
- **Push while full.**
  - With a pop on that channel in the same cycle: push accepted, count unchanged.
  - Otherwise: tag dropped, count unchanged, `overflow` set until reset.
- **Push and pop same cycle, not full.** Count unchanged, both pointers advance.
- **Push to empty channel during HOLDOFF.** Queued normally; `Ri` rises only after the hold expires.
- **Reset (any cycle, including mid-grant).** Pointers, counts and hold counters clear; all FSMs go to IDLE; every output drives 0 (`R0`, `R1`, `gnt*_valid`, `gnt*_tag`, `full*`, `count*`, `overflow`). Pushes and grants in the reset cycle are ignored.

## Timing
- **Push → request.** Push accepted at edge n into an empty, non-holding channel → `Ri`=1 from cycle n+1.
- **Grant → report.** Grant sampled at edge m → `gnti_valid`=1 and `gnti_tag` during cycle m+1 only. In the same cycle m+1, `Ri`=0.
- **Request gap.** `Ri` stays 0 for cycles m+1 through m+HOLD, and returns to 1 at m+HOLD+1 if count>0. Minimum request gap is HOLD cycles, so one arbiter grant yields exactly one pop.
- **Flag update.** `full*`, `count*` and `overflow` update one cycle after the causing edge.
- **No combinational paths** from any input to any output.

## Structure
- **Package `request_pkg`:**
  - Default constants for DEPTH, TAG_W and HOLD.
  - Channel-state enum IDLE/REQ/HOLDOFF.
  - `tag_t` typedef.
- **Sub-module `req_channel`:** one FIFO, its FSM and hold counter, with its push/tag/G/R/gnt/full/count ports plus a drop strobe. Instantiated twice.
- **Top level:** ORs the two drop strobes into the sticky `overflow`.

## Test plan
- **Reset values.** Reset low 2 cycles with `push0`=1 → all outputs 0, count0=0. Release reset, push tag0=0x5 → `R0`=1 next cycle, count0=1.
- **Grant and hold-off.** Push 0x1, 0x2 on channel 0; drive `G0`=1 while `R0`=1 → next cycle `gnt0_valid`=1, `gnt0_tag`=0x1, `R0`=0 for 1 cycle, then `R0`=1. Second grant → tag 0x2, count0=0, `R0` stays 0.
- **Fill and overflow.** Push 5 tags into DEPTH=4 channel 1 with no grants → count1=4, `full1`=1, `overflow`=1 and stays set. Grants return tags in order 1,2,3,4, not the 5th.
- **Full with push and grant together.** Channel full, push and valid grant in the same cycle → push accepted, count stays 4, `overflow` stays 0.
- **Simultaneous grants and ignored grants.** Both channels non-empty, `G0`=`G1`=1 in one cycle → both `gnt*_valid` pulse the same cycle. `G0`=1 held through HOLDOFF → no extra pop.
- **Reset mid-operation.** Reset asserted in the grant cycle with count0=3 → no `gnt0_valid`, count0=0, `R0`=0.
